// File: rtl/cla_pipe_adder_if.sv
// Operand/result channel of the pipelined carry-lookahead adder.
// Valid/ready semantics on both sides: a transfer happens on a rising clock
// edge where valid and ready are both high; the producer keeps its payload
// stable and valid asserted until that edge, and ready may depend
// combinationally on the consumer side of the same channel.
interface cla_pipe_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;

    // Operand producer / result consumer side.
    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co, ovf
    );

    // The adder itself.
    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co, ovf
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder: s = a + b + ci over WIDTH bits.
// Each stage resolves one SW-bit slice with BLKS_PER_STAGE rippled 4-bit
// lookahead blocks, passes its carry to the next stage, and carries the
// still-unused upper operand bits and the already-finished lower sum bits
// along with it. The whole pipe advances together or stalls together.
module cla_pipe_adder #(
    parameter int WIDTH          = 32,
    parameter int BLKS_PER_STAGE = 2
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave bus
);
    localparam int SW     = 4 * BLKS_PER_STAGE;
    localparam int NSTAGE = WIDTH / SW;

    if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_width
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of 4*BLKS_PER_STAGE");
    end

    // Single global advance: the pipe moves whenever the output slot is
    // empty or being consumed; bubbles are carried, never squeezed.
    logic adv;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        logic            v_in;
        logic [SW-1:0]   a_sl;
        logic [SW-1:0]   b_sl;
        logic            c_in;
        logic [SW-1:0]   g;
        logic [SW-1:0]   p;
        logic [SW:0]     c;
        logic [SW-1:0]   sum_sl;
        logic [(k+1)*SW-1:0] sum_d;
        logic            v_q;
        logic            c_q;
        logic [(k+1)*SW-1:0] sum_q;

        if (k == 0) begin : g_first
            assign v_in  = bus.in_valid;
            assign a_sl  = bus.a[SW-1:0];
            assign b_sl  = bus.b[SW-1:0];
            assign c_in  = bus.ci;
            assign sum_d = sum_sl;
        end else begin : g_next
            assign v_in  = g_stage[k-1].v_q;
            assign a_sl  = g_stage[k-1].g_fwd.a_up_q[SW-1:0];
            assign b_sl  = g_stage[k-1].g_fwd.b_up_q[SW-1:0];
            assign c_in  = g_stage[k-1].c_q;
            assign sum_d = {sum_sl, g_stage[k-1].sum_q};
        end

        // Slice sum: per-bit generate/propagate, full lookahead inside each
        // 4-bit block, block carries rippled across the stage.
        always_comb begin
            logic [3:0] gb;
            logic [3:0] pb;
            logic       cb;
            g    = a_sl & b_sl;
            p    = a_sl ^ b_sl;
            c    = '0;
            c[0] = c_in;
            gb   = '0;
            pb   = '0;
            cb   = 1'b0;
            for (int j = 0; j < BLKS_PER_STAGE; j++) begin
                gb = g[4*j +: 4];
                pb = p[4*j +: 4];
                cb = c[4*j];
                c[4*j+1] = gb[0] | (pb[0] & cb);
                c[4*j+2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & cb);
                c[4*j+3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
                         | (pb[2] & pb[1] & pb[0] & cb);
                c[4*j+4] = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
                         | (pb[3] & pb[2] & pb[1] & gb[0])
                         | (pb[3] & pb[2] & pb[1] & pb[0] & cb);
            end
            sum_sl = p ^ c[SW-1:0];
        end

        // Stage register: valid bit always follows on advance; payload is
        // only loaded for a real operand so outputs stay at their reset
        // values until the first result appears.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                v_q <= v_in;
                if (v_in) begin
                    c_q   <= c[SW];
                    sum_q <= sum_d;
                end
            end
        end

        if (k < NSTAGE - 1) begin : g_fwd
            localparam int UPW = WIDTH - (k + 1) * SW;
            logic [UPW-1:0] a_up_d;
            logic [UPW-1:0] b_up_d;
            logic [UPW-1:0] a_up_q;
            logic [UPW-1:0] b_up_q;

            if (k == 0) begin : g_src_bus
                assign a_up_d = bus.a[WIDTH-1:SW];
                assign b_up_d = bus.b[WIDTH-1:SW];
            end else begin : g_src_prev
                assign a_up_d = g_stage[k-1].g_fwd.a_up_q[WIDTH-k*SW-1:SW];
                assign b_up_d = g_stage[k-1].g_fwd.b_up_q[WIDTH-k*SW-1:SW];
            end

            // Skew register for the operand bits later stages still need.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_up_q <= '0;
                    b_up_q <= '0;
                end else if (adv && v_in) begin
                    a_up_q <= a_up_d;
                    b_up_q <= b_up_d;
                end
            end
        end else begin : g_last
            logic cm_q;

            // Carry into the MSB, kept alongside the final carry for ovf.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cm_q <= 1'b0;
                end else if (adv && v_in) begin
                    cm_q <= c[SW-1];
                end
            end
        end
    end

    assign adv           = ~g_stage[NSTAGE-1].v_q | bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = g_stage[NSTAGE-1].v_q;
    assign bus.s         = g_stage[NSTAGE-1].sum_q;
    assign bus.co        = g_stage[NSTAGE-1].c_q;
    assign bus.ovf       = g_stage[NSTAGE-1].g_last.cm_q ^ g_stage[NSTAGE-1].c_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder (WIDTH=32, BLKS_PER_STAGE=2, four stages).
module tb_cla_pipe_adder;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    // Clock and reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_pipe_adder_if #(.WIDTH(W)) bus ();

    cla_pipe_adder #(
        .WIDTH         (W),
        .BLKS_PER_STAGE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain integer arithmetic. Returns {co, ovf, s}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci);
        logic [W:0] full;
        longint     sv;
        longint     max_s;
        longint     min_s;
        logic       ov;
        full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        sv    = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        max_s = (longint'(1) <<< (W - 1)) - 1;
        min_s = -(longint'(1) <<< (W - 1));
        ov    = (sv > max_s) || (sv < min_s);
        return {full[W], ov, full[W-1:0]};
    endfunction

    // Scoreboard
    logic [W+1:0] exp_q[$];
    logic [W-1:0] log_s[$];
    int           log_cyc[$];
    int           acc_cyc[$];
    bit           seen_first = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            seen_first = 0;
        end else begin
            check("in_ready_rule", {63'd0, bus.in_ready}, {63'd0, (~bus.out_valid | bus.out_ready)});
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.a, bus.b, bus.ci));
                acc_cyc.push_back(cyc);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: got s=0x%0h with nothing outstanding", bus.s);
                end else begin
                    check("result", {30'd0, bus.co, bus.ovf, bus.s}, {30'd0, exp_q[0]});
                    if (bus.out_ready) begin
                        void'(exp_q.pop_front());
                        log_s.push_back(bus.s);
                        log_cyc.push_back(cyc);
                        seen_first = 1;
                    end
                end
            end else if (!seen_first) begin
                check("idle_outputs_reset", {30'd0, bus.co, bus.ovf, bus.s}, 64'd0);
            end
        end
    end

    // Driver tasks
    task automatic single(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                          input logic [W-1:0] es, input logic eco, input logic eov,
                          input string name);
        int lat;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_s"}, {32'd0, bus.s}, {32'd0, es});
        check({name, "_co"}, {63'd0, bus.co}, {63'd0, eco});
        check({name, "_ovf"}, {63'd0, bus.ovf}, {63'd0, eov});
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input int kind);
        bit acc;
        int guard;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            if (kind == 0) begin
                bus.a  = W'(i);
                bus.b  = W'(3 * i);
                bus.ci = 1'b0;
            end else begin
                bus.a  = 32'hFFFF_FFF0 + W'(i * 7);
                bus.b  = W'(i) * 32'h1111_1111;
                bus.ci = i[0];
            end
            acc   = 0;
            guard = 0;
            while (!acc && guard < 50) begin
                @(negedge clk);
                acc = bus.in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) begin
                n_total++;
                $display("FAIL stream_accept_timeout: operand %0d not accepted in %0d cycles", i, guard);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && guard < budget) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_in_budget", {63'd0, guard < budget}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int base_s;
        int base_acc;
        int g;
        int vseen;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("reset_s", {32'd0, bus.s}, 64'd0);
        check("reset_co", {63'd0, bus.co}, 64'd0);
        check("reset_ovf", {63'd0, bus.ovf}, 64'd0);
        rst = 1'b0;
        #1;
        check("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Directed single operations with hand-computed results
        single(32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, "basic");
        single(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "carry_chain");
        single(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "pos_ovf");
        single(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "neg_ovf");
        single(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 32'h2222_2222, 1'b0, 1'b0, "mixed");

        // Back-to-back: 8 operands (i, 3i), results 4i on consecutive cycles
        base_s   = log_s.size();
        base_acc = acc_cyc.size();
        stream(8, 0);
        wait_drain(50);
        check("b2b_count", 64'(log_s.size() - base_s), 64'd8);
        if (log_s.size() - base_s == 8 && acc_cyc.size() - base_acc == 8) begin
            for (int j = 0; j < 8; j++) begin
                check("b2b_s", {32'd0, log_s[base_s+j]}, 64'(4 * j));
                check("b2b_latency", 64'(log_cyc[base_s+j] - acc_cyc[base_acc+j]), 64'd4);
                if (j > 0) check("b2b_spacing", 64'(log_cyc[base_s+j] - log_cyc[base_s+j-1]), 64'd1);
            end
        end

        // Backpressure: stall the consumer for 3 cycles mid-stream
        base_s = log_s.size();
        fork
            stream(6, 1);
            begin
                g = 0;
                while (!bus.out_valid && g < 50) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", {63'd0, bus.in_ready}, 64'd0);
                    check("stall_out_valid", {63'd0, bus.out_valid}, 64'd1);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain(50);
        check("bp_count", 64'(log_s.size() - base_s), 64'd6);

        // Reset mid-flight: two operands in the pipe, then reset
        bus.a        = 32'h0000_0001;
        bus.b        = 32'h0000_0002;
        bus.ci       = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.a = 32'h0000_0003;
        bus.b = 32'h0000_0004;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_s", {32'd0, bus.s}, 64'd0);
        check("midrst_co", {63'd0, bus.co}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        vseen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) vseen++;
        end
        check("midrst_no_stale", 64'(vseen), 64'd0);
        single(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, "post_reset");
        wait_drain(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
